player_move_tx: RTL and testbench



---
 rtl/player_move_tx.sv | 151 +++++++++++++++
 tb/tb_player_move_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_tx.sv
// Purpose: drives one player move bus plus a registered strobe with fixed setup/pulse/hold timing.
// Latency: the bus changes at the accept edge; the strobe rises SETUP_CYC edges later; ack arrives SETUP_CYC+PULSE_CYC+HOLD_CYC edges later.
// Backpressure: ready is low for the whole transfer, and req is ignored (no err, no queueing) until ready returns.
module player_move_tx #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic [2:0] sel,
    input  logic [2:0] move,
    input  logic [2:0] turn,
    input  logic       turn_check_en,
    output logic       ready,
    output logic       ack,
    output logic       err,
    output logic [2:0] player1,
    output logic [2:0] player2,
    output logic [2:0] player3,
    output logic [2:0] player4,
    output logic [2:0] player5,
    output logic [2:0] player6,
    output logic [5:0] player_clk,
    output logic [7:0] tx_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PULSE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Each phase counts down from its reload value to zero, so one phase lasts exactly its cycle count.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       move_q, move_d;
    logic [5:0][2:0]  bus_q, bus_d;
    logic [5:0]       pclk_d;
    logic             ready_d, ack_d, err_d;
    logic [7:0]       tx_d;
    logic             bad_req;

    // A request is rejected when the player index is out of range, or when turn checking is enabled and the index is not the current turn.
    assign bad_req = (sel > 3'd5) || (turn_check_en && (sel != turn));

    // Next-state logic. Every output is computed here and then registered, so the strobe cannot glitch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        move_d  = move_q;
        bus_d   = bus_q;
        pclk_d  = player_clk;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        tx_d    = tx_count;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d   = sel;
                        move_d  = move;
                        for (int i = 0; i < 6; i++) begin
                            if (sel == 3'(i)) bus_d[i] = move;
                        end
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    pclk_d  = 6'b000001 << sel_q;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    pclk_d  = 6'b000000;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b1;
                    tx_d    = tx_count + 8'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                pclk_d  = 6'b000000;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers. Reset clears the strobes and buses immediately, with no ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sel_q      <= 3'd0;
            move_q     <= 3'd0;
            bus_q      <= '0;
            player_clk <= 6'b000000;
            ready      <= 1'b1;
            ack        <= 1'b0;
            err        <= 1'b0;
            tx_count   <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            move_q     <= move_d;
            bus_q      <= bus_d;
            player_clk <= pclk_d;
            ready      <= ready_d;
            ack        <= ack_d;
            err        <= err_d;
            tx_count   <= tx_d;
        end
    end

    assign player1 = bus_q[0];
    assign player2 = bus_q[1];
    assign player3 = bus_q[2];
    assign player4 = bus_q[3];
    assign player5 = bus_q[4];
    assign player6 = bus_q[5];

endmodule

// File: tb/tb_player_move_tx.sv
// Purpose: bench for player_move_tx. Two instances (default timing, and 1/3/1 timing) share one stimulus stream.
// Latency: each instance is compared each cycle against a timestamp model that schedules events relative to the accept edge.
// Backpressure: the model ignores req while a transfer is in flight, exactly as the host contract describes.
module tb_player_move_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req = 1'b0;
    logic [2:0] sel = 3'd0;
    logic [2:0] move = 3'd0;
    logic [2:0] turn = 3'd0;
    logic       tce = 1'b0;

    logic            d_rdy  [2];
    logic            d_ack  [2];
    logic            d_err  [2];
    logic [5:0]      d_pclk [2];
    logic [7:0]      d_tx   [2];
    logic [5:0][2:0] pb     [2];

    int ps[2] = '{2, 1};
    int pp[2] = '{2, 3};
    int ph[2] = '{2, 1};

    // Reference model state, one copy per instance.
    logic            m_act  [2];
    int              m_acc  [2];
    logic [2:0]      m_sel  [2];
    logic [5:0][2:0] m_bus  [2];
    logic [5:0]      m_pclk [2];
    logic            m_rdy  [2];
    logic            m_ack  [2];
    logic            m_err  [2];
    logic [7:0]      m_cnt  [2];

    int edge_n = 0;
    int checks = 0;
    int failures = 0;
    int acks_seen0 = 0;

    always #5 clk = ~clk;

    player_move_tx u0 (
        .clk(clk), .reset_n(reset_n), .req(req), .sel(sel), .move(move),
        .turn(turn), .turn_check_en(tce),
        .ready(d_rdy[0]), .ack(d_ack[0]), .err(d_err[0]),
        .player1(pb[0][0]), .player2(pb[0][1]), .player3(pb[0][2]),
        .player4(pb[0][3]), .player5(pb[0][4]), .player6(pb[0][5]),
        .player_clk(d_pclk[0]), .tx_count(d_tx[0])
    );

    player_move_tx #(.SETUP_CYC(1), .PULSE_CYC(3), .HOLD_CYC(1), .CNT_W(4)) u1 (
        .clk(clk), .reset_n(reset_n), .req(req), .sel(sel), .move(move),
        .turn(turn), .turn_check_en(tce),
        .ready(d_rdy[1]), .ack(d_ack[1]), .err(d_err[1]),
        .player1(pb[1][0]), .player2(pb[1][1]), .player3(pb[1][2]),
        .player4(pb[1][3]), .player5(pb[1][4]), .player6(pb[1][5]),
        .player_clk(d_pclk[1]), .tx_count(d_tx[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int k);
        m_act[k]  = 1'b0;
        m_acc[k]  = 0;
        m_sel[k]  = 3'd0;
        m_bus[k]  = '0;
        m_pclk[k] = 6'b0;
        m_rdy[k]  = 1'b1;
        m_ack[k]  = 1'b0;
        m_err[k]  = 1'b0;
        m_cnt[k]  = 8'd0;
    endtask

    // Timestamp model: after an accept at edge a, the strobe is high after edges a+S .. a+S+P-1, and ack occurs at edge a+S+P+H.
    task automatic model_step(input int k);
        int t_all;
        t_all    = ps[k] + pp[k] + ph[k];
        m_ack[k] = 1'b0;
        m_err[k] = 1'b0;
        if (!reset_n) begin
            model_clear(k);
            return;
        end
        if (m_act[k]) begin
            if (edge_n == m_acc[k] + t_all) begin
                m_ack[k] = 1'b1;
                m_cnt[k] = m_cnt[k] + 8'd1;
                m_act[k] = 1'b0;
            end
        end else if (req) begin
            if (sel > 3'd5 || (tce && sel != turn)) begin
                m_err[k] = 1'b1;
            end else begin
                m_act[k]        = 1'b1;
                m_acc[k]        = edge_n;
                m_sel[k]        = sel;
                m_bus[k][sel]   = move;
            end
        end
        if (m_act[k] && edge_n >= m_acc[k] + ps[k] && edge_n < m_acc[k] + ps[k] + pp[k])
            m_pclk[k] = 6'b000001 << m_sel[k];
        else
            m_pclk[k] = 6'b000000;
        m_rdy[k] = !m_act[k];
    endtask

    task automatic compare(input int k);
        chk($sformatf("u%0d_ready@%0d", k, edge_n), 32'(d_rdy[k]), 32'(m_rdy[k]));
        chk($sformatf("u%0d_ack@%0d", k, edge_n), 32'(d_ack[k]), 32'(m_ack[k]));
        chk($sformatf("u%0d_err@%0d", k, edge_n), 32'(d_err[k]), 32'(m_err[k]));
        chk($sformatf("u%0d_pclk@%0d", k, edge_n), 32'(d_pclk[k]), 32'(m_pclk[k]));
        chk($sformatf("u%0d_buses@%0d", k, edge_n), 32'(pb[k]), 32'(m_bus[k]));
        chk($sformatf("u%0d_txcnt@%0d", k, edge_n), 32'(d_tx[k]), 32'(m_cnt[k]));
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        for (int k = 0; k < 2; k++) model_step(k);
        @(negedge clk);
        for (int k = 0; k < 2; k++) compare(k);
        if (d_ack[0]) acks_seen0++;
    endtask

    // Reset asserted mid-cycle: the outputs must clear without waiting for a clock edge.
    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            model_clear(k);
            compare(k);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) model_clear(k);
        // Reset, then idle.
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Basic send with the turn check on.
        tce = 1'b1; turn = 3'd0; sel = 3'd0; move = 3'b101; req = 1'b1;
        tick();
        req = 1'b0;
        repeat (8) tick();
        chk("basic_tx_u0", 32'(d_tx[0]), 32'd1);
        chk("basic_p1_u0", 32'(pb[0][0]), 32'd5);

        // Wrong turn, then a bad index with the turn check off.
        turn = 3'd2; sel = 3'd4; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tce = 1'b0; sel = 3'd6; req = 1'b1;
        tick();
        req = 1'b0;
        repeat (2) tick();

        // Back-to-back transfers with req held high.
        sel = 3'd3; move = 3'b010; req = 1'b1;
        tick();
        sel = 3'd5; move = 3'b111;
        repeat (12) tick();
        req = 1'b0;
        repeat (10) tick();

        // A req during PULSE is ignored; then reset hits mid-pulse.
        sel = 3'd1; move = 3'd3; req = 1'b1;
        tick();
        req = 1'b0;
        repeat (2) tick();
        sel = 3'd2; move = 3'd6; req = 1'b1;
        tick();
        req = 1'b0;
        async_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Randomized traffic, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            req  = ($urandom_range(0, 9) < 6);
            sel  = 3'($urandom_range(0, 7));
            move = 3'($urandom);
            tce  = 1'($urandom);
            turn = ($urandom_range(0, 1) == 1) ? sel : 3'($urandom_range(0, 5));
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
                tick();
                reset_n = 1'b1;
            end
            tick();
        end

        // 256 transfers on the default instance make tx_count wrap to 0.
        req = 1'b0;
        async_reset();
        tick();
        reset_n = 1'b1;
        tick();
        acks_seen0 = 0;
        tce = 1'b0; req = 1'b1;
        for (int g = 0; g < 4000 && acks_seen0 < 256; g++) begin
            sel  = 3'($urandom_range(0, 5));
            move = 3'($urandom);
            tick();
        end
        req = 1'b0;
        repeat (8) tick();
        chk("wrap_acks_u0", 32'(acks_seen0), 32'd256);
        chk("wrap_txcnt_u0", 32'(d_tx[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
